// File: rtl/sd_pkg.sv
// Shared definitions for the SD DAT0 block receiver.
// Contents: FSM state encoding, Avalon register addresses, STATUS bit
// positions, and the CRC16-CCITT polynomial with a one-bit update helper.
package sd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        DATA,
        CRC,
        END
    } state_e;

    localparam logic [1:0] ADDR_CTRL = 2'd0;
    localparam logic [1:0] ADDR_DATA = 2'd1;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_CRC_ERR = 2;
    localparam int STAT_TIMEOUT = 3;
    localparam int STAT_EMPTY   = 4;
    localparam int STAT_FULL    = 5;
    localparam int STAT_CNT_LSB = 8;

    localparam logic [15:0] CRC16_POLY = 16'h1021;

    // One serial CRC16 step, data bit entering MSB-first.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                               input logic        din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/sd_crc16.sv
// Serial CRC16-CCITT (poly 0x1021, init 0x0000) accumulator.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clr_i        : return the CRC to 0 (takes priority over en_i)
//   en_i         : fold bit_i into the CRC this cycle
//   bit_i        : serial data bit, MSB-first
//   crc_o        : current CRC value
module sd_crc16
    import sd_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = 16'h0000;
        end else if (en_i) begin
            crc_d = crc16_step(crc_q, bit_i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q <= 16'h0000;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sd_dat_block_rx.sv
// SD-card single-block receiver on DAT0 with an Avalon-MM slave port.
// Generates sd_clk, waits for the start bit, deserialises BLOCK_BYTES bytes
// into a byte FIFO, then checks the CRC16 and the end bit.
// Ports:
//   clk, reset_n        : system clock, asynchronous active-low reset
//   address             : 0 = CTRL (write) / STATUS (read), 1 = DATA (read)
//   chipselect, read_n,
//   write_n, writedata  : Avalon-MM slave strobes and write data
//   readdata            : registered read data, latency 1
//   sd_dat              : DAT0 pad value (asynchronous to clk)
//   sd_clk              : SD clock to the card
module sd_dat_block_rx
    import sd_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int BLOCK_BYTES = 512,
    parameter int TIMEOUT     = 65535,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        sd_dat,
    output logic        sd_clk
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int WAIT_W = $clog2(TIMEOUT);
    localparam int BYTE_W = $clog2(BLOCK_BYTES);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = AW + 1;

    logic              sd_dat_m_q, sd_dat_s_q;
    state_e            state_q, state_d;
    logic              sd_clk_q, sd_clk_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [15:0]       crc_rx_q, crc_rx_d;
    logic [3:0]        crc_cnt_q, crc_cnt_d;
    logic [7:0]        pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic              done_q, done_d;
    logic              crc_err_q, crc_err_d;
    logic              timeout_q, timeout_d;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       readdata_q, readdata_d;
    logic [31:0]       status;
    logic [15:0]       crc_calc;

    logic ctrl_wr, data_rd, fifo_empty, fifo_full, push, pop;
    logic stall, clk_run, tick, sample, start;
    logic wdata_unused;

    assign wdata_unused = ^writedata[31:1];

    assign ctrl_wr    = chipselect & ~write_n & (address == ADDR_CTRL);
    assign data_rd    = chipselect & ~read_n & (address == ADDR_DATA);
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign pop        = data_rd & ~fifo_empty;
    // A pop in the same cycle frees the slot the pending byte needs.
    assign push       = pend_vld_q & (~fifo_full | pop);
    // While a completed byte cannot enter the FIFO the divider freezes;
    // a byte only completes on a falling edge, so sd_clk is held low.
    assign stall      = pend_vld_q & ~push;
    assign clk_run    = (state_q != IDLE) & ~stall;
    assign tick       = clk_run & (div_cnt_q == DIV_W'(CLK_DIV - 1));
    assign sample     = tick & sd_clk_q;
    assign start      = ctrl_wr & writedata[0] & (state_q == IDLE);

    sd_crc16 u_crc (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (start),
        .en_i    (sample & (state_q == DATA)),
        .bit_i   (sd_dat_s_q),
        .crc_o   (crc_calc)
    );

    always_comb begin
        state_d    = state_q;
        sd_clk_d   = sd_clk_q;
        div_cnt_d  = div_cnt_q;
        wait_cnt_d = wait_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        crc_rx_d   = crc_rx_q;
        crc_cnt_d  = crc_cnt_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q & ~push;
        done_d     = done_q;
        crc_err_d  = crc_err_q;
        timeout_d  = timeout_q;

        if (clk_run) begin
            if (tick) begin
                div_cnt_d = '0;
                sd_clk_d  = ~sd_clk_q;
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = WAIT_START;
                    done_d     = 1'b0;
                    crc_err_d  = 1'b0;
                    timeout_d  = 1'b0;
                    wait_cnt_d = '0;
                    div_cnt_d  = '0;
                    sd_clk_d   = 1'b0;
                end
            end
            WAIT_START: begin
                if (sample) begin
                    if (!sd_dat_s_q) begin
                        state_d    = DATA;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                    end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    shift_d   = {shift_q[6:0], sd_dat_s_q};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        // Any earlier pending byte is being pushed this
                        // cycle, otherwise the clock would be stalled.
                        pend_d     = shift_d;
                        pend_vld_d = 1'b1;
                        byte_cnt_d = byte_cnt_q + BYTE_W'(1);
                        if (byte_cnt_q == BYTE_W'(BLOCK_BYTES - 1)) begin
                            state_d   = CRC;
                            crc_cnt_d = '0;
                        end
                    end
                end
            end
            CRC: begin
                if (sample) begin
                    crc_rx_d  = {crc_rx_q[14:0], sd_dat_s_q};
                    crc_cnt_d = crc_cnt_q + 4'd1;
                    if (crc_cnt_q == 4'd15) begin
                        state_d = END;
                    end
                end
            end
            END: begin
                if (sample) begin
                    crc_err_d = (crc_rx_q != crc_calc) | ~sd_dat_s_q;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        status                     = '0;
        status[STAT_BUSY]          = (state_q != IDLE);
        status[STAT_DONE]          = done_q;
        status[STAT_CRC_ERR]       = crc_err_q;
        status[STAT_TIMEOUT]       = timeout_q;
        status[STAT_EMPTY]         = fifo_empty;
        status[STAT_FULL]          = fifo_full;
        status[STAT_CNT_LSB +: 8]  = 8'(cnt_q);
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_CTRL: readdata_d = status;
            ADDR_DATA: readdata_d = fifo_empty ? 32'h0 : {24'h0, mem_q[rd_ptr_q]};
            default:   readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sd_dat_m_q <= 1'b1;
            sd_dat_s_q <= 1'b1;
            state_q    <= IDLE;
            sd_clk_q   <= 1'b0;
            div_cnt_q  <= '0;
            wait_cnt_q <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            crc_rx_q   <= '0;
            crc_cnt_q  <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            done_q     <= 1'b0;
            crc_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            readdata_q <= '0;
        end else begin
            sd_dat_m_q <= sd_dat;
            sd_dat_s_q <= sd_dat_m_q;
            state_q    <= state_d;
            sd_clk_q   <= sd_clk_d;
            div_cnt_q  <= div_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            crc_rx_q   <= crc_rx_d;
            crc_cnt_q  <= crc_cnt_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            done_q     <= done_d;
            crc_err_q  <= crc_err_d;
            timeout_q  <= timeout_d;
            readdata_q <= readdata_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // FIFO storage holds no control state; emptiness is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= pend_q;
    end

    assign readdata = readdata_q;
    assign sd_clk   = sd_clk_q;

endmodule

// File: tb/tb_sd_dat_block_rx.sv
module tb_sd_dat_block_rx;

    localparam int BB = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        read_n = 1'b1;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'h0;
    logic [31:0] readdata;
    logic        sd_dat = 1'b1;
    logic        sd_clk;

    int checks = 0;
    int errors = 0;
    int rise_cnt = 0;
    logic card_q [$];

    sd_dat_block_rx #(
        .CLK_DIV     (3),
        .BLOCK_BYTES (BB),
        .TIMEOUT     (100),
        .FIFO_DEPTH  (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .sd_dat     (sd_dat),
        .sd_clk     (sd_clk)
    );

    initial forever #5 clk = ~clk;

    // Card model: drives the next bit on each sd_clk falling edge, idles high.
    always @(negedge sd_clk or negedge reset_n) begin
        if (!reset_n) sd_dat = 1'b1;
        else if (card_q.size() > 0) sd_dat = card_q.pop_front();
        else sd_dat = 1'b1;
    end

    always @(posedge sd_clk) rise_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          mode;       // 0: all 0xFF, 1: ramp 0x00,0x01,...
        logic        crc_flip;
        logic        end_bit;
        int          restart_at; // issue a CTRL start after this many pops, -1 none
        logic [31:0] exp_status;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input int mode, input int i);
        return (mode == 0) ? 8'hFF : 8'(i);
    endfunction

    // Byte-wise CRC16 XMODEM reference.
    function automatic logic [15:0] model_crc(input int mode);
        logic [15:0] c;
        c = 16'h0000;
        for (int i = 0; i < BB; i++) begin
            c = c ^ {byte_of(mode, i), 8'h00};
            for (int k = 0; k < 8; k++)
                c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; read_n = 1'b0;
        @(posedge clk); #1;
        d = readdata;
        chipselect = 1'b0; read_n = 1'b1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] v);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = v;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
    endtask

    task automatic load_card(input int mode, input logic crc_flip, input logic end_bit);
        logic [15:0] c;
        logic [7:0]  b;
        c = model_crc(mode) ^ {15'h0, crc_flip};
        card_q.delete();
        repeat (4) card_q.push_back(1'b1);
        card_q.push_back(1'b0);
        for (int i = 0; i < BB; i++) begin
            b = byte_of(mode, i);
            for (int j = 7; j >= 0; j--) card_q.push_back(b[j]);
        end
        for (int j = 15; j >= 0; j--) card_q.push_back(c[j]);
        card_q.push_back(end_bit);
    endtask

    task automatic drain(input int mode, input int first, input int last, input int restart_at);
        int idx;
        int guard;
        logic [31:0] st, d;
        idx = first;
        guard = 0;
        while (idx < last && guard < 20000) begin
            bus_read(2'd0, st);
            if (!st[4]) begin
                bus_read(2'd1, d);
                check("data_byte", d, {24'h0, byte_of(mode, idx)});
                idx++;
                if (idx == restart_at) bus_write(2'd0, 32'h1);
            end
            guard++;
        end
        check("drain_count", 32'(idx), 32'(last));
    endtask

    task automatic wait_idle();
        logic [31:0] st;
        int guard;
        guard = 0;
        bus_read(2'd0, st);
        while (st[0] && guard < 3000) begin
            bus_read(2'd0, st);
            guard++;
        end
        check("idle_reached", {31'h0, st[0]}, 32'h0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [31:0] st;
        load_card(v.mode, v.crc_flip, v.end_bit);
        bus_write(2'd0, 32'h1);
        drain(v.mode, 0, BB, v.restart_at);
        wait_idle();
        bus_read(2'd0, st);
        check(tag, st, v.exp_status);
    endtask

    initial begin
        logic [31:0] st, d;
        int r0;
        int guard;
        logic seen;

        vecs[0] = '{0, 1'b0, 1'b1, -1, 32'h12};
        vecs[1] = '{0, 1'b1, 1'b1, -1, 32'h16};
        vecs[2] = '{0, 1'b0, 1'b0, -1, 32'h16};
        vecs[3] = '{1, 1'b0, 1'b1, 10, 32'h12};
        vecs[4] = '{1, 1'b1, 1'b1, -1, 32'h16};

        // Reset state
        #23;
        check("rst_readdata", readdata, 32'h0);
        check("rst_sdclk", {31'h0, sd_clk}, 32'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        bus_read(2'd0, st);
        check("rst_status", st, 32'h10);
        bus_read(2'd1, d);
        check("empty_pop_data", d, 32'h0);
        bus_read(2'd0, st);
        check("empty_pop_status", st, 32'h10);
        bus_read(2'd2, d);
        check("addr2_reads0", d, 32'h0);

        // Table-driven blocks
        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d_status", i));

        // Timeout: card never sends a start bit
        card_q.delete();
        r0 = rise_cnt;
        bus_write(2'd0, 32'h1);
        bus_read(2'd0, st);
        check("to_busy", st, 32'h11);
        wait_idle();
        check("to_rises", 32'(rise_cnt - r0), 32'd100);
        bus_read(2'd0, st);
        check("to_status", st, 32'h18);
        cyc(30);
        check("to_sdclk_low", {31'h0, sd_clk}, 32'h0);
        check("to_no_more_rises", 32'(rise_cnt - r0), 32'd100);

        // FIFO-full stall and resume
        load_card(1, 1'b0, 1'b1);
        bus_write(2'd0, 32'h1);
        guard = 0;
        bus_read(2'd0, st);
        while (st[15:8] != 8'd16 && guard < 5000) begin
            bus_read(2'd0, st);
            guard++;
        end
        check("stall_fill", {24'h0, st[15:8]}, 32'd16);
        cyc(150);
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            cyc(1);
            if (sd_clk) seen = 1'b1;
        end
        check("stall_sdclk_low", {31'h0, seen}, 32'h0);
        bus_read(2'd0, st);
        check("stall_status", st, 32'h1021);
        bus_read(2'd1, d);
        check("stall_pop", d, 32'h00);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            cyc(1);
            if (sd_clk) seen = 1'b1;
        end
        check("stall_resume", {31'h0, seen}, 32'h1);
        drain(1, 1, BB, -1);
        wait_idle();
        bus_read(2'd0, st);
        check("stall_final", st, 32'h12);

        // Reset mid-DATA after 37 bytes, then a fresh block
        load_card(1, 1'b0, 1'b1);
        bus_write(2'd0, 32'h1);
        drain(1, 0, 37, -1);
        reset_n = 1'b0;
        #1;
        card_q.delete();
        check("mid_rst_sdclk", {31'h0, sd_clk}, 32'h0);
        check("mid_rst_readdata", readdata, 32'h0);
        #20;
        reset_n = 1'b1;
        @(posedge clk); #1;
        bus_read(2'd0, st);
        check("mid_rst_status", st, 32'h10);
        run_vec(vecs[0], "fresh_status");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_dat_block_rx.md
Name: sd_dat_block_rx

Overview:
- Hardware receiver for one SD-card data block on DAT0, with an Avalon-MM slave interface. It replaces CPU bit-banging of the SD_DAT PIO for reads.
- Generates SD_CLK, waits for the start bit, and deserialises BLOCK_BYTES bytes into a byte FIFO.
- Checks CRC16 and the end bit, and reports status to the Nios driver.
- Sits between the SD_DAT pad input (pad still owned by the PIO; PIO direction = input during reads) and the Avalon fabric.

Parameters:
- CLK_DIV, 4: sd_clk half-period in clk cycles; minimum 3.
- BLOCK_BYTES, 512: payload bytes per block.
- TIMEOUT, 65535: sd_clk rising edges allowed in WAIT_START before abort.
- FIFO_DEPTH, 16: byte FIFO entries, power of two.

Ports:
- clk  in  1  system clock
- reset_n  in  1  async active-low reset
- address  in  2  0 = CTRL/STATUS, 1 = DATA
- chipselect  in  1  Avalon select
- read_n  in  1  Avalon read strobe, active low
- write_n  in  1  Avalon write strobe, active low
- writedata  in  32  write data
- readdata  out  32  registered read data
- sd_dat  in  1  DAT0 pad value
- sd_clk  out  1  SD clock to card

Behaviour:
- Reset:
  - Decided: reset reset_n, asynchronous, active-low; clock clk.
  - Reset clears everything: readdata=0, sd_clk=0, state=IDLE, FIFO empty, all flags 0, counters 0.
  - Reset asserted mid-operation aborts immediately; no flags survive.
- Input synchroniser: sd_dat passes through 2 flops; the result is sd_dat_s.
- sd_clk generation:
  - Runs only outside IDLE.
  - Toggles every CLK_DIV clk cycles.
  - A bit is taken as sd_dat_s on the clk cycle in which sd_clk goes 1->0.
- Clock stall: if the FIFO is full when a byte completes (or a byte is pending push), sd_clk holds low and the divider freezes until a pop frees a slot. No data is ever dropped.
- CTRL write (address 0, chipselect, ~write_n):
  - writedata[0]=1 while in IDLE clears done, crc_err and timeout, then enters WAIT_START.
  - Start while busy is ignored.
  - Other bits are ignored.
  - FIFO is not flushed by start.
- STATUS read (address 0) bits:
  - [0] busy
  - [1] done
  - [2] crc_err
  - [3] timeout
  - [4] fifo_empty
  - [5] fifo_full
  - [15:8] fifo count
  - All other bits 0.
- DATA read (address 1, chipselect, ~read_n):
  - readdata <= {24'b0, FIFO head}.
  - Pop occurs in the same cycle.
  - Pop on empty returns 0 and leaves state unchanged.
- Read latency: readdata registered every clk from the address mux; read latency 1; addresses 2-3 read 0.
- Simultaneous push and pop: both happen; count unchanged.
- State machine:
  - IDLE: waits for start.
  - WAIT_START:
    - Each sample of 0 -> DATA.
    - Each sample of 1 increments the wait counter; at TIMEOUT samples -> set timeout -> IDLE.
  - DATA: MSB-first shift; each 8 bits push a byte; after BLOCK_BYTES bytes -> CRC.
  - CRC: receive 16 bits MSB-first.
  - END: sample end bit; crc_err = (rx CRC != computed) OR (end bit == 0); set done -> IDLE.
- CRC: CRC16-CCITT, poly 0x1021, init 0x0000, computed over DATA bits only. Updated on each data sample.
- Flag clearing: flags are sticky until the next start or reset.

Decomposition:
- Shared package sd_pkg:
  - state enum (IDLE, WAIT_START, DATA, CRC, END)
  - register addresses ADDR_CTRL=0, ADDR_DATA=1
  - status bit indices
  - CRC16_POLY=16'h1021
- One natural sub-module: sd_crc16 (serial CRC; inputs clr, en, bit; output crc[15:0]).
- FIFO and divider stay inline.

Test Plan:
- Block of 512 x 0xFF, CRC 0x7FA1, end bit 1, model card driving on sd_clk falling edge -> 512 pops all return 0xFF; final STATUS done=1, crc_err=0, timeout=0, busy=0.
- Same block sent with CRC 0x7FA0 -> all bytes delivered; done=1, crc_err=1. Separately, correct CRC with end bit 0 -> crc_err=1.
- TIMEOUT=100, sd_dat held 1 after start -> exactly 100 sd_clk rising edges, then timeout=1, busy=0, sd_clk stays 0, FIFO empty.
- Block with bytes 0x00..0xFF repeated, no pops -> sd_clk stops low with count=16 and fifo_full=1. Pop one byte (returns 0x00) -> sd_clk resumes. Draining continuously yields an in-order sequence, no loss.
- reset_n pulsed low in DATA after 37 bytes -> STATUS reads 0x10 (fifo_empty only), sd_clk=0, readdata=0. A new start then receives a fresh block correctly.
- Start written while busy -> no restart; byte order is unaffected. DATA read on empty FIFO -> readdata=0 and count stays 0.
